// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle between keypad_scan (master) and its consumer (slave).
interface keypad_scan_if;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_press;
    logic [15:0] key_edge;
    logic [3:0]  key_code;
    logic        key_valid;

    modport master (
        input  row_in,
        output col_out, key_press, key_edge, key_code, key_valid
    );

    modport slave (
        output row_in,
        input  col_out, key_press, key_edge, key_code, key_valid
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: per-key debounce, level/edge vectors, lowest held key code.
// Optional KEY_REPEAT_EN adds auto-repeat pulses on key_edge for the held key_code.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY   = 50,
    parameter int unsigned REPEAT_RATE    = 10
`endif
) (
    input logic           clk,
    input logic           rst,
    keypad_scan_if.master kp
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Legend at {row, col}; bit k of every key vector is legend hex k.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic [3:0]    row_meta_q, row_sync_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic [1:0]    col_q, col_d;
    logic [3:0]    col_drv_q, col_drv_d;
    logic [15:0]   press_q, press_d;
    logic [15:0]   edge_q, edge_d;
    logic [3:0]    cnt_q [16];
    logic [3:0]    cnt_d [16];
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic [15:0]   rep_edge;
    logic [3:0]    key;

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d   = tick ? '0 : presc_q + PW'(1);
        col_d     = col_q;
        col_drv_d = col_drv_q;
        press_d   = press_q;
        cnt_d     = cnt_q;
        key       = '0;
        if (tick) begin
            col_d     = col_q + 2'd1;
            col_drv_d = ~(4'd1 << col_d);
            for (int r = 0; r < 4; r++) begin
                key = KEY_MAP[{2'(r), col_q}];
                if (~row_sync_q[r] == press_q[key]) begin
                    cnt_d[key] = '0;
                end else if (cnt_q[key] == 4'(DEBOUNCE_SCANS - 1)) begin
                    press_d[key] = ~press_q[key];
                    cnt_d[key]   = '0;
                end else begin
                    cnt_d[key] = cnt_q[key] + 4'd1;
                end
            end
        end

        valid_d = |press_d;
        code_d  = '0;
        for (int i = 15; i >= 0; i--) begin
            if (press_d[i]) code_d = 4'(i);
        end

        edge_d = (press_d & ~press_q) | rep_edge;
    end

`ifdef KEY_REPEAT_EN
    localparam int unsigned RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_armed_q, rep_armed_d;
    logic          wrap;

    assign wrap = tick && (col_q == 2'd3);

    // Frames are counted at column wrap; first pulse after REPEAT_DELAY, then every REPEAT_RATE.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_edge    = '0;
        if ((valid_d != valid_q) || (code_d != code_q)) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (wrap && valid_q) begin
            if (rep_cnt_q == RW'(rep_armed_q ? REPEAT_RATE - 1 : REPEAT_DELAY - 1)) begin
                rep_edge    = 16'd1 << code_q;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_edge = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
            presc_q    <= '0;
            col_q      <= '0;
            col_drv_q  <= 4'b1110;
            press_q    <= '0;
            edge_q     <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
        end else begin
            row_meta_q <= kp.row_in;
            row_sync_q <= row_meta_q;
            presc_q    <= presc_d;
            col_q      <= col_d;
            col_drv_q  <= col_drv_d;
            press_q    <= press_d;
            edge_q     <= edge_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign kp.col_out   = col_drv_q;
    assign kp.key_press = press_q;
    assign kp.key_edge  = edge_q;
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad, debounces each key and produces level and edge vectors.
- key_press[15:0] and key_edge[15:0] feed the downstream space-allocation block directly; that block consumes key_edge[9:1] as digits 1-9.
- Bit k of each vector corresponds to the key whose legend is hex k.

Parameters:
- SCAN_DIV, 100000: clk cycles per column slot (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, 4: consecutive disagreeing samples needed to flip a key state; range 1-15.
- REPEAT_DELAY, 50: frames a key is held before the first auto-repeat (only with KEY_REPEAT_EN).
- REPEAT_RATE, 10: frames between auto-repeats (only with KEY_REPEAT_EN).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col_out  out  4  column drive, one-cold, active-low
- key_press  out  16  debounced level per key, 1 = held
- key_edge  out  16  one-cycle pulse per key on press
- key_code  out  4  lowest-index held key
- key_valid  out  1  any key held

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - col_out=4'b1110
  - key_press=0, key_edge=0, key_code=0, key_valid=0
  - prescaler, column index and all debounce counters = 0
- Legend map, row r, col c:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Synchronizer: row_in passes through a 2-flop synchronizer before use.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. The terminal count is the "tick".
- Sampling and column advance:
  - On a tick, sample the synchronized rows for the current column: raw = ~row_sync.
  - In the same cycle, advance the column index (0→1→2→3→0) and update col_out = ~(1<<idx).
  - Column settle time is therefore one full slot.
- Frame: 4 slots = 4*SCAN_DIV cycles.
- Debounce, per key, on that key's sample only:
  - If raw == key_press[k], clear cnt[k].
  - Otherwise increment cnt[k]. When cnt[k] reaches DEBOUNCE_SCANS, toggle key_press[k] and clear cnt[k] in the same cycle.
  - Each key is sampled once per frame, so a flip needs DEBOUNCE_SCANS frames of stability.
- Edge: key_edge[k]=1 for exactly the single cycle in which key_press[k] first reads 1.
  - Release produces no edge.
  - Up to 4 edge bits may be set together (same column).
- key_valid / key_code: registered and updated every cycle from the key_press value of the next state.
  - key_valid = |key_press.
  - key_code = index of the lowest set bit, or 0 when none is set.
- Ghosting: not suppressed. With 3 or more keys held, phantom keys are reported as raw presses.
- Reset mid-debounce: all state clears immediately. A key still held after reset is re-debounced from zero and produces a fresh edge.
- Latency: press-to-key_press is at most DEBOUNCE_SCANS frames + 1 slot + 3 cycles.

Optional Feature:
- Macro KEY_REPEAT_EN.
- Defined:
  - One frame counter tracks key_code while key_valid=1.
  - The counter restarts when key_code changes or key_valid falls.
  - After REPEAT_DELAY frames held, pulse key_edge[key_code] for one cycle, then again every REPEAT_RATE frames.
  - Repeat pulses are aligned to the tick at which the column index wraps from 3 to 0.
- Undefined: no repeat logic is synthesized; key_edge pulses only on debounced press.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame=16 cycles):
1. Hold row1 low while col1 is driven (key 5) → key_press=16'h0020 within 55 cycles; key_edge=16'h0020 for exactly 1 cycle; key_code=5, key_valid=1.
2. Press key 5 for 2 samples, then release (bounce) → key_press, key_edge and key_valid stay 0 throughout.
3. Release key 5 after a stable press → key_press=0 after 3 frames, no key_edge pulse, key_valid=0, key_code=0.
4. Hold keys 1 (r0c0) and 9 (r2c2) together → key_press=16'h0202, with separate single-cycle edges on bits 1 and 9; key_code=1.
5. Assert rst for 1 cycle mid-debounce of key 8 → all outputs reset at once, col_out=4'b1110. Key 8 still held → new edge 16'h0100 after 3 frames.
6. KEY_REPEAT_EN, REPEAT_DELAY=2, REPEAT_RATE=1, key 3 held 8 frames → initial edge, then a repeat key_edge=16'h0008 every frame from frame 2 after press.
